// File: rtl/axis_burst_m.sv
// axis_burst_m: AXI-Stream burst master.
//   On start (in IDLE, len != 0) emits len beats of incrementing data starting
//   at base, tlast on the final beat, then pulses finish for one cycle.
// Ports:
//   aclk, areset_n      clock, synchronous active-low reset
//   start, len, base    burst request (sampled only in IDLE)
//   busy, finish        user-side status (busy through burst, finish pulse)
//   tvalid/tready/tdata/tlast  AXI-Stream master interface
// All outputs are registered; tvalid never depends combinationally on tready.
module axis_burst_m #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] base,
  output logic              busy,
  output logic              finish,
  output logic              tvalid,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;     // index of the beat currently presented
  logic [DATA_W-1:0] tdata_q;
  logic              tvalid_q, tlast_q, busy_q, finish_q;

  logic              hs;
  logic [LEN_W-1:0]  cnt_d;
  logic              tlast_d;

  assign hs      = tvalid_q & tready;
  assign cnt_d   = cnt_q + 1'b1;
  // Beat cnt_q+1 is the last one when cnt_q+2 == len; widened so len=max
  // does not alias through the add.
  assign tlast_d = ({1'b0, cnt_q} + (LEN_W+1)'(2)) == {1'b0, len_q};

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          finish_q <= 1'b0;
          if (start && len != '0) begin
            len_q    <= len;
            cnt_q    <= '0;
            tdata_q  <= base;
            tlast_q  <= (len == LEN_W'(1));
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              finish_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              tdata_q <= tdata_q + 1'b1;  // wraps modulo 2**DATA_W
              cnt_q   <= cnt_d;
              tlast_q <= tlast_d;
            end
          end
        end
        DONE: begin
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign finish = finish_q;
  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign tlast  = tlast_q;

endmodule

// File: tb/tb_axis_burst_m.sv
// Directed bench for axis_burst_m. Stimulus pushes expected beats into a
// queue; the monitor pops on every handshake, checks hold-stability during
// stalls, and checks finish pulses.
module tb_axis_burst_m;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              aclk = 1'b0;
  logic              areset_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] base = '0;
  logic              busy, finish, tvalid, tlast;
  logic              tready = 1'b0;
  logic [DATA_W-1:0] tdata;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int fin_cnt = 0;

  axis_burst_m #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .aclk(aclk), .areset_n(areset_n), .start(start), .len(len), .base(base),
    .busy(busy), .finish(finish), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tlast(tlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic              stall_p = 1'b0;
  logic [DATA_W-1:0] stall_d;
  logic              stall_l;
  logic              fin_p = 1'b0;
  always @(negedge aclk) begin
    if (!areset_n) begin
      stall_p = 1'b0;
      fin_p   = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_tvalid", 64'(tvalid), 64'd1);
        chk("stall_tdata", 64'(tdata), 64'(stall_d));
        chk("stall_tlast", 64'(tlast), 64'(stall_l));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(tdata), 64'hDEAD_BEEF_0000_0000);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_tdata", 64'(tdata), 64'(e.data));
          chk("beat_tlast", 64'(tlast), 64'(e.last));
        end
      end
      stall_p = tvalid && !tready;
      stall_d = tdata;
      stall_l = tlast;
      if (finish) begin
        fin_cnt++;
        chk("finish_beats_left", 64'(exp_q.size()), 64'd0);
        chk("finish_one_cycle", 64'(fin_p), 64'd0);
      end
      fin_p = finish;
    end
  end

  // Drive a request; the next rising edge samples it. Returns at edge+1.
  task automatic do_start(input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] b, input bit push);
    start = 1'b1; len = l; base = b;
    if (push) begin
      for (int i = 0; i < int'(l); i++) begin
        beat_t e;
        e.data = b + DATA_W'(i);
        e.last = (i == int'(l) - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  // Count falling edges until finish is seen; bounded.
  task automatic wait_fin(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge aclk);
      n++;
      if (finish) return;
    end
    chk("finish_timeout", 64'(n), 64'hFFFF);
  endtask

  int n, f0;
  logic [5:0] pat;

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(posedge aclk); #1;

    // 1: len=4 base=0x10, tready=1
    tready = 1'b1;
    f0 = fin_cnt;
    do_start(8'd4, 32'h10, 1'b1);
    wait_fin(20, n);
    chk("t1_latency", 64'(n), 64'd5);
    @(negedge aclk);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_fin_count", 64'(fin_cnt - f0), 64'd1);
    @(posedge aclk); #1;

    // 2: len=3 base=0x100, tready 0,1,0,0,1,1
    tready = 1'b0;
    f0 = fin_cnt;
    do_start(8'd3, 32'h100, 1'b1);
    pat = 6'b110010; // applied LSB first
    for (int i = 0; i < 6; i++) begin
      tready = pat[i];
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    chk("t2_finish", 64'(finish), 64'd1);
    chk("t2_left", 64'(exp_q.size()), 64'd0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk("t2_fin_count", 64'(fin_cnt - f0), 64'd1);

    // 3: wrap
    tready = 1'b1;
    do_start(8'd3, 32'hFFFF_FFFE, 1'b1);
    wait_fin(20, n);
    chk("t3_latency", 64'(n), 64'd4);
    @(posedge aclk); #1;
    @(posedge aclk); #1;

    // 4: start during burst ignored, len=0 ignored
    f0 = fin_cnt;
    do_start(8'd2, 32'h20, 1'b1);
    do_start(8'd5, 32'h50, 1'b0);
    wait_fin(20, n);
    repeat (8) @(posedge aclk);
    #1;
    chk("t4_fin_count", 64'(fin_cnt - f0), 64'd1);
    f0 = fin_cnt;
    do_start(8'd0, 32'h77, 1'b0);
    @(negedge aclk);
    chk("t4_len0_tvalid", 64'(tvalid), 64'd0);
    chk("t4_len0_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge aclk);
    #1;
    chk("t4_len0_fin", 64'(fin_cnt - f0), 64'd0);

    // 5: reset after second handshake of len=6
    f0 = fin_cnt;
    do_start(8'd6, 32'h200, 1'b1);
    @(posedge aclk); #1;   // handshake 1
    @(posedge aclk); #1;   // handshake 2
    areset_n = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    @(posedge aclk); #1;
    chk("t5_tvalid", 64'(tvalid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    areset_n = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk("t5_no_fin", 64'(fin_cnt - f0), 64'd0);
    do_start(8'd1, 32'd7, 1'b1);
    wait_fin(20, n);
    chk("t5_latency", 64'(n), 64'd2);
    @(posedge aclk); #1;

    // 6: single beat timing
    do_start(8'd1, 32'hA5, 1'b1);
    @(negedge aclk);
    chk("t6_tvalid", 64'(tvalid), 64'd1);
    chk("t6_tlast", 64'(tlast), 64'd1);
    chk("t6_busy", 64'(busy), 64'd1);
    @(negedge aclk);
    chk("t6_finish", 64'(finish), 64'd1);
    chk("t6_tvalid_off", 64'(tvalid), 64'd0);
    @(negedge aclk);
    chk("t6_finish_off", 64'(finish), 64'd0);
    chk("t6_busy_off", 64'(busy), 64'd0);
    chk("t6_left", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
